arm_seq: RTL and testbench
==========================

ARM_SEQ -- requirements
Module: arm_seq

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: clk input 1, rising-edge clock; reset input 1, asynchronous, active-high.
REQ-002 SHALL have port imem_data input 16, instruction word returned for imem_addr.
REQ-003 SHALL have port zero input 1, high when the ALU rd_data operand is 0; sampled in EXEC1.
REQ-004 SHALL have port run input 1, level; leaves HALT.
REQ-005 SHALL have port imem_ready input 1 (only with ARM_SEQ_WAIT_EN), high when imem_data is valid.
REQ-006 SHALL have port imem_addr output 8, equal to pc.
REQ-007 SHALL have port inst output 16, registered instruction fed to the ALU.
REQ-008 SHALL have port state output 3, one-hot phase: FETCH=001, EXEC1=010, EXEC2=100, HALT=000.
REQ-009 SHALL have port halted output 1, high in HALT.
REQ-010 SHALL have port retire output 1, one-cycle pulse when an instruction completes.
REQ-011 SHALL have port icount output 16, retired-instruction counter.

Function
REQ-012 SHALL decode ldr as inst[15:12]=1110, HALT op as inst[15:12]=0001, JMP as 0100, JZ as 0101; all other words execute in EXEC1 only.
REQ-013 FETCH SHALL latch imem_data into inst, set pc=pc+1 modulo 256 and go to EXEC1 at the clock edge, when the fetch is accepted (always, or imem_ready=1 under the macro).
REQ-014 Under ARM_SEQ_WAIT_EN, FETCH with imem_ready=0 SHALL hold state, pc and inst unchanged.
REQ-015 EXEC1 with ldr SHALL go to EXEC2; EXEC2 SHALL go to FETCH with retire=1.
REQ-016 EXEC1 with HALT op SHALL go to HALT with retire=1; pc is not modified.
REQ-017 EXEC1 with JMP SHALL load pc=inst[7:0] and go to FETCH with retire=1.
REQ-018 EXEC1 with JZ SHALL load pc=inst[7:0] if zero=1, else leave pc; go to FETCH with retire=1.
REQ-019 EXEC1 with any other word SHALL go to FETCH with retire=1.
REQ-020 HALT SHALL hold all registers and go to FETCH on the first edge with run=1; run is ignored in other states.
REQ-021 retire SHALL be combinational from the current state and inst, asserted during the final execute cycle of each instruction.
REQ-022 icount SHALL increment by 1 on every edge where retire=1 and wrap 0xFFFF->0x0000.
REQ-023 Latency without wait states SHALL be 2 cycles per non-ldr instruction and 3 cycles per ldr.
REQ-024 state SHALL never take a value outside the four encodings; an illegal value SHALL go to FETCH on the next edge.

Reset
REQ-025 Reset SHALL force state=FETCH (001), pc=0, inst=0x0000, icount=0, halted=0, retire=0 immediately and asynchronously.
REQ-026 Reset asserted mid-instruction SHALL abandon it without retire or icount change; the first fetch after release is from address 0.

Configuration
REQ-027 Macro ARM_SEQ_WAIT_EN defined SHALL add the imem_ready input and the FETCH stall of REQ-014.
REQ-028 Without ARM_SEQ_WAIT_EN, imem_ready SHALL be absent and every FETCH SHALL be accepted in one cycle.

Verification
REQ-029 Reset, memory of three 0x8000 words -> state sequence 001,010 repeating; pc 0->1->2->3; icount=3 after 6 cycles.
REQ-030 Word at addr 0 = 0xE005 (ldr) -> states 001,010,100,001; retire only in the 100 cycle; icount=1.
REQ-031 addr 0 = 0x4010 (JMP) -> next imem_addr=0x10; addr 0 = 0x5020 (JZ) with zero=0 -> next imem_addr=0x01, with zero=1 -> 0x20.
REQ-032 addr 0 = 0x1000 (HALT) -> state=000, halted=1 and pc=1 held for 10 cycles with run=0; run=1 for one cycle -> FETCH from addr 1.
REQ-033 pc=0xFF executing 0x8000 -> next imem_addr=0x00; preload icount 0xFFFF via 65535 retires -> wraps to 0x0000.
REQ-034 Reset asserted during EXEC2 of an ldr -> state=001, pc=0, icount unchanged from before that ldr; with ARM_SEQ_WAIT_EN, imem_ready=0 for 4 cycles in FETCH -> state, pc, inst all held, then accepted on the cycle imem_ready=1.

Source files
------------

// File: rtl/arm_seq.sv
// arm_seq: FETCH / EXEC1 / EXEC2 / HALT instruction sequencer with a retire counter.
// Define ARM_SEQ_WAIT_EN to add the imem_ready input and stall FETCH until the word is valid.
module arm_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] imem_data,
    input  logic        zero,
    input  logic        run,
`ifdef ARM_SEQ_WAIT_EN
    input  logic        imem_ready,
`endif
    output logic [7:0]  imem_addr,
    output logic [15:0] inst,
    output logic [2:0]  state,
    output logic        halted,
    output logic        retire,
    output logic [15:0] icount
);

    typedef enum logic [2:0] {
        ST_HALT  = 3'b000,
        ST_FETCH = 3'b001,
        ST_EXEC1 = 3'b010,
        ST_EXEC2 = 3'b100
    } state_e;

    localparam logic [3:0] OP_LDR  = 4'b1110;
    localparam logic [3:0] OP_HALT = 4'b0001;
    localparam logic [3:0] OP_JMP  = 4'b0100;
    localparam logic [3:0] OP_JZ   = 4'b0101;

    state_e      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] inst_q, inst_d;
    logic [15:0] icount_q, icount_d;
    logic        retire_c;
    logic        fetch_ok;

    logic [3:0]  op;
    logic        is_ldr;
    logic        is_halt;
    logic        is_jmp;
    logic        is_jz;
    logic        take_jump;

`ifdef ARM_SEQ_WAIT_EN
    assign fetch_ok = imem_ready;
`else
    assign fetch_ok = 1'b1;
`endif

    assign op        = inst_q[15:12];
    assign is_ldr    = (op == OP_LDR);
    assign is_halt   = (op == OP_HALT);
    assign is_jmp    = (op == OP_JMP);
    assign is_jz     = (op == OP_JZ);
    assign take_jump = is_jmp || (is_jz && zero);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        retire_c = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (fetch_ok) begin
                    inst_d  = imem_data;
                    pc_d    = pc_q + 8'd1;
                    state_d = ST_EXEC1;
                end
            end
            ST_EXEC1: begin
                if (is_ldr) begin
                    state_d = ST_EXEC2;
                end else begin
                    retire_c = 1'b1;
                    state_d  = is_halt ? ST_HALT : ST_FETCH;
                    if (take_jump) begin
                        pc_d = inst_q[7:0];
                    end
                end
            end
            ST_EXEC2: begin
                retire_c = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_HALT: begin
                if (run) begin
                    state_d = ST_FETCH;
                end
            end
            // Any corrupted encoding recovers through FETCH without retiring.
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    assign icount_d = icount_q + {15'd0, retire_c};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_FETCH;
            pc_q     <= 8'h00;
            inst_q   <= 16'h0000;
            icount_q <= 16'h0000;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            icount_q <= icount_d;
        end
    end

    assign imem_addr = pc_q;
    assign inst      = inst_q;
    assign state     = state_q;
    assign halted    = (state_q == ST_HALT);
    assign retire    = retire_c;
    assign icount    = icount_q;

endmodule

// File: tb/tb_arm_seq.sv
// tb_arm_seq: directed scenarios plus a randomized program run against an
// instruction-level reference model of the sequencer.
module tb_arm_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] imem_data;
    logic        zero = 1'b0;
    logic        run = 1'b0;
`ifdef ARM_SEQ_WAIT_EN
    logic        imem_ready = 1'b1;
`endif
    logic [7:0]  imem_addr;
    logic [15:0] inst;
    logic [2:0]  state;
    logic        halted;
    logic        retire;
    logic [15:0] icount;

    logic [15:0] mem [256];

    int checks = 0;
    int errors = 0;

    arm_seq dut (
        .clk       (clk),
        .reset     (reset),
        .imem_data (imem_data),
        .zero      (zero),
        .run       (run),
`ifdef ARM_SEQ_WAIT_EN
        .imem_ready(imem_ready),
`endif
        .imem_addr (imem_addr),
        .inst      (inst),
        .state     (state),
        .halted    (halted),
        .retire    (retire),
        .icount    (icount)
    );

    assign imem_data = mem[imem_addr];

    always #5 clk = ~clk;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic fill(input logic [15:0] w);
        for (int i = 0; i < 256; i++) mem[i] = w;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        fill(16'h8000);
        do_reset();
        tick(); tick(); tick();
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({state, imem_addr, inst, icount, halted, retire} !==
            {3'b001, 8'h00, 16'h0000, 16'h0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_async: got st=%b pc=%h inst=%h ic=%h h=%b r=%b expected 001/00/0000/0000/0/0",
                     state, imem_addr, inst, icount, halted, retire);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_seq;
        logic [2:0]  est;
        logic [7:0]  epc;
        logic [15:0] eic;
        logic        er;
        fill(16'h8000);
        do_reset();
        for (int c = 0; c < 6; c++) begin
            est = (c % 2 == 0) ? 3'b001 : 3'b010;
            epc = 8'((c + 1) / 2);
            eic = 16'(c / 2);
            er  = (c % 2 == 1);
            checks++;
            if ({state, imem_addr, icount, retire} !== {est, epc, eic, er}) begin
                errors++;
                $display("FAIL seq_c%0d: got st=%b pc=%h ic=%h r=%b expected st=%b pc=%h ic=%h r=%b",
                         c, state, imem_addr, icount, retire, est, epc, eic, er);
            end
            tick();
        end
        checks++;
        if ({state, imem_addr, icount} !== {3'b001, 8'h03, 16'd3}) begin
            errors++;
            $display("FAIL seq_end: got st=%b pc=%h ic=%h expected 001/03/0003",
                     state, imem_addr, icount);
        end
    endtask

    task automatic test_ldr;
        logic [2:0] sts [4];
        logic       rts [4];
        sts = '{3'b001, 3'b010, 3'b100, 3'b001};
        rts = '{1'b0, 1'b0, 1'b1, 1'b0};
        fill(16'h8000);
        mem[0] = 16'hE005;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            checks++;
            if ({state, retire, icount} !== {sts[c], rts[c], (c == 3) ? 16'd1 : 16'd0}) begin
                errors++;
                $display("FAIL ldr_c%0d: got st=%b r=%b ic=%h expected st=%b r=%b",
                         c, state, retire, icount, sts[c], rts[c]);
            end
            tick();
        end
    endtask

    task automatic test_jump;
        logic [15:0] words [3];
        logic        zs    [3];
        logic [7:0]  tgt   [3];
        words = '{16'h4010, 16'h5020, 16'h5020};
        zs    = '{1'b0, 1'b0, 1'b1};
        tgt   = '{8'h10, 8'h01, 8'h20};
        for (int k = 0; k < 3; k++) begin
            fill(16'h8000);
            mem[0] = words[k];
            zero = zs[k];
            do_reset();
            tick(); tick();
            checks++;
            if ({state, imem_addr} !== {3'b001, tgt[k]}) begin
                errors++;
                $display("FAIL jump_%0d: got st=%b pc=%h expected st=001 pc=%h",
                         k, state, imem_addr, tgt[k]);
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_halt;
        fill(16'h8000);
        mem[0] = 16'h1000;
        run = 1'b0;
        do_reset();
        tick(); tick();
        for (int c = 0; c < 10; c++) begin
            checks++;
            if ({state, halted, imem_addr, icount} !== {3'b000, 1'b1, 8'h01, 16'd1}) begin
                errors++;
                $display("FAIL halt_c%0d: got st=%b h=%b pc=%h ic=%h expected 000/1/01/0001",
                         c, state, halted, imem_addr, icount);
            end
            tick();
        end
        run = 1'b1;
        tick();
        run = 1'b0;
        checks++;
        if ({state, halted, imem_addr} !== {3'b001, 1'b0, 8'h01}) begin
            errors++;
            $display("FAIL halt_resume: got st=%b h=%b pc=%h expected 001/0/01",
                     state, halted, imem_addr);
        end
        tick();
        checks++;
        if ({state, inst, imem_addr} !== {3'b010, 16'h8000, 8'h02}) begin
            errors++;
            $display("FAIL halt_refetch: got st=%b inst=%h pc=%h expected 010/8000/02",
                     state, inst, imem_addr);
        end
    endtask

    task automatic test_pc_wrap;
        fill(16'h8000);
        mem[0] = 16'h40FF;
        do_reset();
        tick(); tick();
        checks++;
        if (imem_addr !== 8'hFF) begin
            errors++;
            $display("FAIL pc_at_ff: got %h expected ff", imem_addr);
        end
        tick();
        checks++;
        if ({state, imem_addr} !== {3'b010, 8'h00}) begin
            errors++;
            $display("FAIL pc_wrap: got st=%b pc=%h expected 010/00", state, imem_addr);
        end
    endtask

    task automatic test_icount_wrap;
        fill(16'h8000);
        do_reset();
        force dut.icount_q = 16'hFFFE;
        #1 release dut.icount_q;
        tick(); tick();
        checks++;
        if (icount !== 16'hFFFF) begin
            errors++;
            $display("FAIL icount_ffff: got %h expected ffff", icount);
        end
        tick(); tick();
        checks++;
        if (icount !== 16'h0000) begin
            errors++;
            $display("FAIL icount_wrap: got %h expected 0000", icount);
        end
    endtask

    task automatic test_reset_mid;
        fill(16'h8000);
        mem[0] = 16'hE005;
        do_reset();
        tick(); tick();
        checks++;
        if ({state, icount} !== {3'b100, 16'd0}) begin
            errors++;
            $display("FAIL mid_pre: got st=%b ic=%h expected 100/0000", state, icount);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({state, imem_addr, icount, retire} !== {3'b001, 8'h00, 16'd0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset: got st=%b pc=%h ic=%h r=%b expected 001/00/0000/0",
                     state, imem_addr, icount, retire);
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
        checks++;
        if ({state, inst, imem_addr} !== {3'b010, 16'hE005, 8'h01}) begin
            errors++;
            $display("FAIL mid_refetch: got st=%b inst=%h pc=%h expected 010/e005/01",
                     state, inst, imem_addr);
        end
    endtask

`ifdef ARM_SEQ_WAIT_EN
    task automatic test_wait;
        fill(16'h8000);
        mem[0] = 16'h1234;
        imem_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if ({state, imem_addr, inst} !== {3'b001, 8'h00, 16'h0000}) begin
                errors++;
                $display("FAIL wait_c%0d: got st=%b pc=%h inst=%h expected 001/00/0000",
                         c, state, imem_addr, inst);
            end
        end
        imem_ready = 1'b1;
        tick();
        checks++;
        if ({state, imem_addr, inst} !== {3'b010, 8'h01, 16'h1234}) begin
            errors++;
            $display("FAIL wait_accept: got st=%b pc=%h inst=%h expected 010/01/1234",
                     state, imem_addr, inst);
        end
    endtask
`endif

    task automatic test_random;
        logic [7:0]  mpc;
        logic [15:0] mcnt;
        logic [15:0] w;
        logic [3:0]  o;
        logic        z;
        for (int i = 0; i < 256; i++) begin
            w = 16'($urandom);
            case ($urandom_range(0, 3))
                0: w[15:12] = 4'hE;
                1: w[15:12] = 4'h4;
                2: w[15:12] = 4'h5;
                default: if (w[15:12] inside {4'h1, 4'h4, 4'h5, 4'hE}) w[15:12] = 4'h8;
            endcase
            mem[i] = w;
        end
        do_reset();
        mpc = 8'h00;
        mcnt = 16'h0000;
        for (int n = 0; n < 300; n++) begin
            w = mem[mpc];
            o = w[15:12];
            z = 1'($urandom_range(0, 1));
            zero = z;
            checks++;
            if ({state, imem_addr, icount} !== {3'b001, mpc, mcnt}) begin
                errors++;
                $display("FAIL rnd_fetch_%0d: got st=%b pc=%h ic=%h expected 001/%h/%h",
                         n, state, imem_addr, icount, mpc, mcnt);
            end
`ifdef ARM_SEQ_WAIT_EN
            if ($urandom_range(0, 3) == 0) begin
                imem_ready = 1'b0;
                tick();
                checks++;
                if ({state, imem_addr} !== {3'b001, mpc}) begin
                    errors++;
                    $display("FAIL rnd_stall_%0d: got st=%b pc=%h expected 001/%h",
                             n, state, imem_addr, mpc);
                end
                imem_ready = 1'b1;
            end
`endif
            tick();
            checks++;
            if ({state, inst, imem_addr, retire} !== {3'b010, w, 8'(mpc + 8'd1), o != 4'hE}) begin
                errors++;
                $display("FAIL rnd_exec_%0d: got st=%b inst=%h pc=%h r=%b expected 010/%h/%h",
                         n, state, inst, imem_addr, retire, w, 8'(mpc + 8'd1));
            end
            if (o == 4'hE) begin
                tick();
                checks++;
                if ({state, retire} !== {3'b100, 1'b1}) begin
                    errors++;
                    $display("FAIL rnd_ldr_%0d: got st=%b r=%b expected 100/1", n, state, retire);
                end
            end
            if (o == 4'h4 || (o == 4'h5 && z)) mpc = w[7:0];
            else mpc = mpc + 8'd1;
            mcnt = mcnt + 16'd1;
            tick();
        end
        zero = 1'b0;
    endtask

    initial begin
        test_reset();
        test_seq();
        test_ldr();
        test_jump();
        test_halt();
        test_pc_wrap();
        test_icount_wrap();
        test_reset_mid();
`ifdef ARM_SEQ_WAIT_EN
        test_wait();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
